board_ctl: RTL and testbench
============================

BOARD_CTL -- requirements
Module: board_ctl

Interface
REQ-001 SHALL have parameter START_TURN, default 1'b0, colour to move after reset (0 white, 1 black).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pick_piece  input  1  level, high while the mouse controller holds a piece.
REQ-005 SHALL have port place_piece  input  1  level, high while the mouse controller reports a drop.
REQ-006 SHALL have port mouse_position  input  6  square under cursor, [5:3] row, [2:0] column.
REQ-007 SHALL have port board  output  4 x [0:7][0:7]  current board, registered.
REQ-008 SHALL have port selected_sq  output  6  latched source square.
REQ-009 SHALL have port selected_valid  output  1  high while a piece is held.
REQ-010 SHALL have port turn  output  1  colour to move.
REQ-011 SHALL have port move_done  output  1  one-cycle pulse per committed move.
REQ-012 SHALL have port last_move  output  12  {from[5:0], to[5:0]} of last committed move.
REQ-013 SHALL have port captured  output  4  piece code removed by last move, 0 if none.

Function
REQ-014 Piece code SHALL be: 0 empty, bit3 colour (0 white, 1 black), bits[2:0] 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
REQ-015 Row 0 SHALL be black back rank, row 7 white back rank, standard initial setup (queen column 3, king column 4).
REQ-016 Inputs pick_piece/place_piece SHALL be registered once; events are rising edges of the registered copies.
REQ-017 FSM states SHALL be IDLE, HELD, WRITE, DONE.
REQ-018 IDLE: pick rising edge on a non-empty square -> latch selected_sq = mouse_position, selected_valid = 1, go HELD; pick on empty square -> stay IDLE.
REQ-019 HELD: place rising edge with destination == selected_sq -> cancel, selected_valid = 0, IDLE, no board change, no move_done.
REQ-020 HELD: place rising edge with destination occupied by same colour as held piece -> reject, same as cancel.
REQ-021 HELD: place rising edge otherwise -> latch destination, go WRITE.
REQ-022 HELD: registered pick falling without place rising in the same cycle -> cancel to IDLE.
REQ-023 Simultaneous pick falling and place rising SHALL be treated as place.
REQ-024 WRITE (one cycle): captured <= board[dest]; board[dest] <= held piece; board[src] <= 0; last_move <= {src, dest}; go DONE.
REQ-025 Promotion: white pawn reaching row 0 SHALL be written as 4'h5, black pawn reaching row 7 as 4'hD.
REQ-026 DONE (one cycle): move_done = 1, turn toggles, selected_valid = 0, go IDLE.
REQ-027 Latency from registered place rising edge to move_done SHALL be exactly 2 clk cycles.
REQ-028 Events arriving in WRITE or DONE SHALL be ignored.

Reset
REQ-029 On rst SHALL set: board to initial setup, turn = START_TURN, state IDLE, selected_sq = 0, selected_valid = 0, move_done = 0, last_move = 0, captured = 0, input edge registers = 0.
REQ-030 rst in any state, including WRITE, SHALL override and discard the pending move.

Configuration
REQ-031 Macro BOARD_TURN_CHECK_EN defined: a pick in IDLE SHALL be accepted only if piece bit3 == turn.
REQ-032 Macro BOARD_TURN_CHECK_EN undefined: any non-empty square SHALL be pickable; turn still toggles.

Structure
REQ-033 Piece code constants, initial board constant and the FSM state typedef SHALL live in a shared package chess_pkg.
REQ-034 One sub-module, board_edge_det (register plus rising and falling edge detect for the two level inputs), is natural; all else inline.

Verification
REQ-035 After reset: board[7][4] = 4'h6, board[0][3] = 4'hD, board[3][3] = 0, turn = 0.
REQ-036 Pick square 6'o64 (row 6, column 4), place square 6'o44 -> board[4][4] = 4'h1, board[6][4] = 0, last_move = {6'o64, 6'o44}, captured = 0, move_done high one cycle 2 cycles after place, turn = 1.
REQ-037 Pick 6'o70, place 6'o71 (own knight) -> rejected, board unchanged, no move_done, selected_valid = 0.
REQ-038 Preload black pawn at 6'o60 (row 6), pick it, place 6'o70 (white rook) -> board[7][0] = 4'hD, captured = 4'h4.
REQ-039 With BOARD_TURN_CHECK_EN and turn = 0, pick black pawn 6'o10 -> stays IDLE, selected_valid = 0.
REQ-040 Assert rst during WRITE -> next cycle board equals initial setup, move_done never pulses.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the board controller.
//   - piece codes: 0 empty, bit3 colour (0 white, 1 black), bits[2:0] piece kind
//   - board_t: 8x8 array of 4-bit piece codes, indexed [row][column]
//   - INIT_BOARD: standard setup, row 0 black back rank, row 7 white back rank
//   - state_e: controller FSM states
//   - promote(): pawn-to-queen substitution on the far rank
package chess_pkg;

  localparam logic [3:0] PC_EMPTY  = 4'h0;
  localparam logic [3:0] PC_PAWN   = 4'h1;
  localparam logic [3:0] PC_KNIGHT = 4'h2;
  localparam logic [3:0] PC_BISHOP = 4'h3;
  localparam logic [3:0] PC_ROOK   = 4'h4;
  localparam logic [3:0] PC_QUEEN  = 4'h5;
  localparam logic [3:0] PC_KING   = 4'h6;
  localparam logic [3:0] PC_BLACK  = 4'h8;

  typedef logic [0:7][0:7][3:0] board_t;

  // Rows listed 0..7; within each row the leftmost nibble is column 0.
  localparam board_t INIT_BOARD = {
    32'hCABDEBAC,  // row 0: black R N B Q K B N R
    32'h99999999,  // row 1: black pawns
    32'h00000000,
    32'h00000000,
    32'h00000000,
    32'h00000000,
    32'h11111111,  // row 6: white pawns
    32'h42356324   // row 7: white R N B Q K B N R
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // White pawns promote on row 0, black pawns on row 7; always to a queen.
  function automatic logic [3:0] promote(input logic [3:0] piece, input logic [2:0] row);
    logic [3:0] res;
    res = piece;
    if (piece[2:0] == PC_PAWN[2:0]) begin
      if (!piece[3] && row == 3'd0) res = PC_QUEEN;
      if (piece[3] && row == 3'd7)  res = PC_BLACK | PC_QUEEN;
    end
    return res;
  endfunction

endpackage

// File: rtl/board_edge_det.sv
// board_edge_det: registers the mouse controller's pick/place levels once and
// derives edge events from the registered copies.
//   clk, rst          : clock, synchronous active-high reset
//   pick_in, place_in : raw level inputs
//   pick_rise         : registered pick went 0 -> 1 this cycle
//   pick_fall         : registered pick went 1 -> 0 this cycle
//   place_rise        : registered place went 0 -> 1 this cycle
module board_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pick_in,
  input  logic place_in,
  output logic pick_rise,
  output logic pick_fall,
  output logic place_rise
);

  logic pick_q, pick_d, pick_prev_q, pick_prev_d;
  logic place_q, place_d, place_prev_q, place_prev_d;

  always_comb begin
    pick_d       = pick_in;
    pick_prev_d  = pick_q;
    place_d      = place_in;
    place_prev_d = place_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pick_q       <= 1'b0;
      pick_prev_q  <= 1'b0;
      place_q      <= 1'b0;
      place_prev_q <= 1'b0;
    end else begin
      pick_q       <= pick_d;
      pick_prev_q  <= pick_prev_d;
      place_q      <= place_d;
      place_prev_q <= place_prev_d;
    end
  end

  assign pick_rise  = pick_q & ~pick_prev_q;
  assign pick_fall  = ~pick_q & pick_prev_q;
  assign place_rise = place_q & ~place_prev_q;

endmodule

// File: rtl/board_ctl.sv
// board_ctl: holds the chess board and commits pick/place moves from a mouse
// controller. No move legality is checked beyond "source not empty" and
// "destination not own colour".
//   Parameter START_TURN : colour to move after reset (0 white, 1 black)
//   clk, rst             : clock, synchronous active-high reset
//   pick_piece           : level, high while a piece is held
//   place_piece          : level, high while a drop is reported
//   mouse_position       : square under cursor, [5:3] row, [2:0] column
//   board                : registered board, board[row][col]
//   selected_sq          : latched source square
//   selected_valid       : high while a piece is held
//   turn                 : colour to move
//   move_done            : one-cycle pulse per committed move
//   last_move            : {from, to} of last committed move
//   captured             : piece removed by last move, 0 if none
//   state_dbg            : current FSM state
// Build option: BOARD_TURN_CHECK_EN restricts picks to the colour to move.
// Events (edges of registered pick/place) are only acted on in IDLE and HELD;
// WRITE and DONE are fixed single-cycle states that ignore them.
module board_ctl
  import chess_pkg::*;
#(
  parameter logic START_TURN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pick_piece,
  input  logic        place_piece,
  input  logic [5:0]  mouse_position,
  output board_t      board,
  output logic [5:0]  selected_sq,
  output logic        selected_valid,
  output logic        turn,
  output logic        move_done,
  output logic [11:0] last_move,
  output logic [3:0]  captured,
  output state_e      state_dbg
);

  logic pick_rise, pick_fall, place_rise;

  board_edge_det u_edge (
    .clk        (clk),
    .rst        (rst),
    .pick_in    (pick_piece),
    .place_in   (place_piece),
    .pick_rise  (pick_rise),
    .pick_fall  (pick_fall),
    .place_rise (place_rise)
  );

  state_e      state_q, state_d;
  board_t      board_q, board_d;
  logic [5:0]  sel_sq_q, sel_sq_d;
  logic        sel_valid_q, sel_valid_d;
  logic [5:0]  dest_q, dest_d;
  logic        turn_q, turn_d;
  logic [11:0] last_move_q, last_move_d;
  logic [3:0]  captured_q, captured_d;

  logic [3:0] cursor_piece;
  logic [3:0] held_piece;
  logic       turn_ok;

  assign cursor_piece = board_q[mouse_position[5:3]][mouse_position[2:0]];
  assign held_piece   = board_q[sel_sq_q[5:3]][sel_sq_q[2:0]];

`ifdef BOARD_TURN_CHECK_EN
  assign turn_ok = (cursor_piece[3] == turn_q);
`else
  assign turn_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    sel_sq_d    = sel_sq_q;
    sel_valid_d = sel_valid_q;
    dest_d      = dest_q;
    turn_d      = turn_q;
    last_move_d = last_move_q;
    captured_d  = captured_q;
    case (state_q)
      IDLE: begin
        if (pick_rise && cursor_piece != PC_EMPTY && turn_ok) begin
          sel_sq_d    = mouse_position;
          sel_valid_d = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        // A place edge wins over a simultaneous pick release.
        if (place_rise) begin
          if (mouse_position == sel_sq_q ||
              (cursor_piece != PC_EMPTY && cursor_piece[3] == held_piece[3])) begin
            sel_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            dest_d  = mouse_position;
            state_d = WRITE;
          end
        end else if (pick_fall) begin
          sel_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        captured_d = board_q[dest_q[5:3]][dest_q[2:0]];
        board_d[dest_q[5:3]][dest_q[2:0]]     = promote(held_piece, dest_q[5:3]);
        board_d[sel_sq_q[5:3]][sel_sq_q[2:0]] = PC_EMPTY;
        last_move_d = {sel_sq_q, dest_q};
        sel_valid_d = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        turn_d  = ~turn_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      board_q     <= INIT_BOARD;
      sel_sq_q    <= '0;
      sel_valid_q <= 1'b0;
      dest_q      <= '0;
      turn_q      <= START_TURN;
      last_move_q <= '0;
      captured_q  <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      sel_sq_q    <= sel_sq_d;
      sel_valid_q <= sel_valid_d;
      dest_q      <= dest_d;
      turn_q      <= turn_d;
      last_move_q <= last_move_d;
      captured_q  <= captured_d;
    end
  end

  assign board          = board_q;
  assign selected_sq    = sel_sq_q;
  assign selected_valid = sel_valid_q;
  assign turn           = turn_q;
  assign move_done      = (state_q == DONE);
  assign last_move      = last_move_q;
  assign captured       = captured_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: directed test of board_ctl. Reset contents and the final
// position after a scripted sequence of moves are checked from square tables;
// multi-cycle corners (latency, reject, cancel, simultaneous release/place,
// reset during WRITE) are hand-written sequences.
module tb_board_ctl;
  import chess_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pick_piece;
  logic        place_piece;
  logic [5:0]  mouse_position;
  board_t      board;
  logic [5:0]  selected_sq;
  logic        selected_valid;
  logic        turn;
  logic        move_done;
  logic [11:0] last_move;
  logic [3:0]  captured;
  state_e      state_dbg;

  board_ctl #(.START_TURN(1'b0)) dut (
    .clk            (clk),
    .rst            (rst),
    .pick_piece     (pick_piece),
    .place_piece    (place_piece),
    .mouse_position (mouse_position),
    .board          (board),
    .selected_sq    (selected_sq),
    .selected_valid (selected_valid),
    .turn           (turn),
    .move_done      (move_done),
    .last_move      (last_move),
    .captured       (captured),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0] sq;
    logic [3:0] exp;
  } sq_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sq_at(input logic [5:0] sq);
    return board[sq[5:3]][sq[2:0]];
  endfunction

  function automatic board_t exp_init();
    board_t b;
    logic [3:0] back [8];
    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][c] = back[c] | 4'h8;
      b[1][c] = 4'h9;
      b[6][c] = 4'h1;
      b[7][c] = back[c];
    end
    return b;
  endfunction

  task automatic check_table(input string name, input sq_vec_t tbl[]);
    for (int i = 0; i < tbl.size(); i++)
      check($sformatf("%s sq %o", name, tbl[i].sq), 32'(sq_at(tbl[i].sq)), 32'(tbl[i].exp));
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    pick_piece  = 1'b0;
    place_piece = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_pick(input logic [5:0] sq);
    mouse_position = sq;
    pick_piece     = 1'b1;
    repeat (3) tick();
  endtask

  // Drives a drop and watches move_done for 8 cycles. first_done is the tick
  // index (1-based, counted from the drive) of the first pulse, -1 if none.
  task automatic do_place(input logic [5:0] sq, input bit drop_pick,
                          output int first_done, output int done_cnt);
    mouse_position = sq;
    place_piece    = 1'b1;
    if (drop_pick) pick_piece = 1'b0;
    first_done = -1;
    done_cnt   = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (move_done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
    end
    release_all();
  endtask

  // Full committed move. Tick 1 registers the input, so a pulse on tick 3
  // is exactly two cycles after the registered place edge.
  task automatic do_move(input string name, input logic [5:0] from, input logic [5:0] to,
                         input bit drop_pick);
    int fd, dc;
    do_pick(from);
    do_place(to, drop_pick, fd, dc);
    check({name, " latency"}, 32'(fd), 32'd3);
    check({name, " pulses"}, 32'(dc), 32'd1);
    check({name, " last_move"}, 32'(last_move), 32'({from, to}));
  endtask

  // ---------------- test ----------------
  initial begin
    sq_vec_t rst_tbl[];
    sq_vec_t end_tbl[];
    int fd, dc;

    rst_tbl = '{
      '{6'o74, 4'h6}, '{6'o03, 4'hD}, '{6'o33, 4'h0}, '{6'o00, 4'hC},
      '{6'o77, 4'h4}, '{6'o04, 4'hE}, '{6'o13, 4'h9}, '{6'o65, 4'h1},
      '{6'o73, 4'h5}, '{6'o71, 4'h2}, '{6'o02, 4'hB}
    };
    end_tbl = '{
      '{6'o44, 4'h1}, '{6'o64, 4'h0}, '{6'o10, 4'h0}, '{6'o60, 4'h0},
      '{6'o70, 4'hD}, '{6'o61, 4'h0}, '{6'o51, 4'h0}, '{6'o01, 4'h5},
      '{6'o00, 4'h0}, '{6'o20, 4'hC}, '{6'o11, 4'h9}, '{6'o71, 4'h2},
      '{6'o74, 4'h6}
    };

    rst = 1'b1;
    pick_piece = 1'b0;
    place_piece = 1'b0;
    mouse_position = 6'o00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check_table("reset", rst_tbl);
    n_checks++;
    if (board !== exp_init()) begin
      n_errors++;
      $display("FAIL reset board: got %h expected %h", board, exp_init());
    end
    check("reset turn", 32'(turn), 32'd0);
    check("reset selected_valid", 32'(selected_valid), 32'd0);
    check("reset move_done", 32'(move_done), 32'd0);
    check("reset last_move", 32'(last_move), 32'd0);
    check("reset captured", 32'(captured), 32'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));

    // White pawn e2-e4 style push.
    do_pick(6'o64);
    check("pick64 selected_valid", 32'(selected_valid), 32'd1);
    check("pick64 selected_sq", 32'(selected_sq), 32'o64);
    do_place(6'o44, 1'b0, fd, dc);
    check("m1 latency", 32'(fd), 32'd3);
    check("m1 pulses", 32'(dc), 32'd1);
    check("m1 dest", 32'(sq_at(6'o44)), 32'h1);
    check("m1 src", 32'(sq_at(6'o64)), 32'h0);
    check("m1 last_move", 32'(last_move), 32'o6444);
    check("m1 captured", 32'(captured), 32'h0);
    check("m1 turn", 32'(turn), 32'd1);
    check("m1 selected_valid", 32'(selected_valid), 32'd0);

    // Drop on own knight: rejected.
    do_pick(6'o70);
    do_place(6'o71, 1'b0, fd, dc);
    check("own-colour pulses", 32'(dc), 32'd0);
    check("own-colour rook", 32'(sq_at(6'o70)), 32'h4);
    check("own-colour knight", 32'(sq_at(6'o71)), 32'h2);
    check("own-colour selected_valid", 32'(selected_valid), 32'd0);
    check("own-colour last_move", 32'(last_move), 32'o6444);
    check("own-colour turn", 32'(turn), 32'd1);

    // Pick on an empty square is ignored.
    do_pick(6'o33);
    check("empty pick selected_valid", 32'(selected_valid), 32'd0);
    check("empty pick state", 32'(state_dbg), 32'(IDLE));
    release_all();

    // Black pawn takes white pawn on row 6 (sets up the promotion case).
    do_move("m2", 6'o10, 6'o60, 1'b0);
    check("m2 captured", 32'(captured), 32'h1);
    check("m2 dest", 32'(sq_at(6'o60)), 32'h9);
    check("m2 turn", 32'(turn), 32'd0);

`ifdef BOARD_TURN_CHECK_EN
    // White to move: black pawn may not be picked.
    do_pick(6'o11);
    check("turn-check selected_valid", 32'(selected_valid), 32'd0);
    check("turn-check state", 32'(state_dbg), 32'(IDLE));
    release_all();
`else
    // Any colour may be picked; releasing pick without a drop cancels.
    do_pick(6'o11);
    check("any-colour pick selected_valid", 32'(selected_valid), 32'd1);
    pick_piece = 1'b0;
    repeat (3) tick();
    check("pick release cancel selected_valid", 32'(selected_valid), 32'd0);
    check("pick release cancel state", 32'(state_dbg), 32'(IDLE));
`endif

    // Drop back on the source square: cancel.
    do_pick(6'o61);
    do_place(6'o61, 1'b0, fd, dc);
    check("same-square pulses", 32'(dc), 32'd0);
    check("same-square piece", 32'(sq_at(6'o61)), 32'h1);
    check("same-square selected_valid", 32'(selected_valid), 32'd0);

    do_move("m3", 6'o61, 6'o51, 1'b0);
    check("m3 turn", 32'(turn), 32'd1);

    // Black pawn reaches row 7 capturing a rook: promotes.
    do_move("m4", 6'o60, 6'o70, 1'b0);
    check("m4 promoted", 32'(sq_at(6'o70)), 32'hD);
    check("m4 captured", 32'(captured), 32'h4);

    // White pawn reaches row 0 capturing a knight: promotes.
    do_move("m5", 6'o51, 6'o01, 1'b0);
    check("m5 promoted", 32'(sq_at(6'o01)), 32'h5);
    check("m5 captured", 32'(captured), 32'hA);

    // Pick release and place edge in the same cycle: treated as a place.
    do_move("m6", 6'o00, 6'o20, 1'b1);
    check("m6 captured", 32'(captured), 32'h0);
    check("m6 turn", 32'(turn), 32'd0);

    check_table("final", end_tbl);

    // Reset while a move sits in WRITE.
    do_pick(6'o62);
    mouse_position = 6'o42;
    place_piece = 1'b1;
    tick();
    tick();
    check("pre-reset state", 32'(state_dbg), 32'(WRITE));
    rst = 1'b1;
    pick_piece = 1'b0;
    place_piece = 1'b0;
    tick();
    n_checks++;
    if (board !== exp_init()) begin
      n_errors++;
      $display("FAIL write-reset board: got %h expected %h", board, exp_init());
    end
    check("write-reset move_done", 32'(move_done), 32'd0);
    check("write-reset state", 32'(state_dbg), 32'(IDLE));
    check("write-reset turn", 32'(turn), 32'd0);
    check("write-reset last_move", 32'(last_move), 32'd0);
    check("write-reset captured", 32'(captured), 32'd0);
    check("write-reset selected_valid", 32'(selected_valid), 32'd0);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (move_done) dc++;
    end
    check("write-reset no pulse", 32'(dc), 32'd0);
    check("write-reset dest square", 32'(sq_at(6'o42)), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
